// File: rtl/trg_frame_builder.sv
// Self-triggering frame builder for one ADC channel: threshold trigger, header/data/footer framing.
// Define FOOTER_HITCNT_EN to put the per-frame over-threshold beat count into the footer.
module trg_frame_builder #(
    parameter int POST_ACQUI_LEN       = 38,
    parameter int ACQUI_LEN            = 100,
    parameter int TIME_STAMP_WIDTH     = 49,
    parameter int ADC_RESOLUTION_WIDTH = 12,
    parameter int S_AXIS_TDATA_WIDTH   = 128,
    parameter int CHANNEL_ID           = 0
) (
    input  logic                                   AXIS_ACLK,
    input  logic                                   AXIS_ARESET,
    input  logic [S_AXIS_TDATA_WIDTH-1:0]          S_AXIS_TDATA,
    input  logic                                   S_AXIS_TVALID,
    input  logic signed [ADC_RESOLUTION_WIDTH:0]   THRESHOLD_VAL,
    input  logic signed [ADC_RESOLUTION_WIDTH-1:0] BASELINE,
    input  logic [TIME_STAMP_WIDTH-1:0]            CURRENT_TIME,
    output logic [S_AXIS_TDATA_WIDTH-1:0]          DOUT,
    output logic                                   DOUT_VALID,
    output logic                                   TRIGGERED
);

    localparam int SAMPLES = S_AXIS_TDATA_WIDTH / 16;
    localparam int CNT_W   = 16;
    localparam int HDR_PAD = S_AXIS_TDATA_WIDTH - 16 - TIME_STAMP_WIDTH - (2 * ADC_RESOLUTION_WIDTH + 1);
    localparam int FTR_PAD = S_AXIS_TDATA_WIDTH - 16 - 2 * CNT_W;

    localparam logic [CNT_W-1:0] POST_LEN = CNT_W'(POST_ACQUI_LEN);
    localparam logic [CNT_W-1:0] MAX_LEN  = CNT_W'(ACQUI_LEN);
    localparam logic [7:0]       CH_ID    = 8'(CHANNEL_ID);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA,
        FOOTER
    } state_t;

    state_t state_q, state_d;

    logic [S_AXIS_TDATA_WIDTH-1:0] r1_data, r2_data;
    logic                          r1_valid, r2_valid;
    logic                          r1_hit, r2_hit;
    logic signed [ADC_RESOLUTION_WIDTH:0] sample_ext;

    logic [CNT_W-1:0] data_cnt_q, data_cnt_d;
    logic [CNT_W-1:0] post_cnt_q, post_cnt_d;
    logic [CNT_W-1:0] hit_field;

    logic [S_AXIS_TDATA_WIDTH-1:0] dout_d;
    logic                          dout_valid_d;
    logic                          emit;

    // Two-deep input pipeline: r1 feeds the trigger, r2 is what reaches DOUT.
    always_ff @(posedge AXIS_ACLK) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (AXIS_ARESET) begin
            r1_data  <= '0;
            r1_valid <= 1'b0;
            r2_data  <= '0;
            r2_valid <= 1'b0;
            r2_hit   <= 1'b0;
        end else begin
            r1_data  <= S_AXIS_TDATA;
            r1_valid <= S_AXIS_TVALID;
            r2_data  <= r1_data;
            r2_valid <= r1_valid;
            r2_hit   <= r1_hit;
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        r1_hit     = 1'b0;
        sample_ext = '0;
        for (int j = 0; j < SAMPLES; j++) begin
            sample_ext = {r1_data[16*j+15], r1_data[16*j+15 -: ADC_RESOLUTION_WIDTH]};
            if (r1_valid && (sample_ext > THRESHOLD_VAL)) begin
                r1_hit = 1'b1;
            end
        end
    end

`ifdef FOOTER_HITCNT_EN
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (state_q == IDLE) begin
            hit_cnt_d = '0;
        end else if (emit && r2_valid && r2_hit && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_field = hit_cnt_q;
`else
    assign hit_field = '0;
`endif

    // The header word is registered at trigger time, so later threshold/baseline changes cannot reach it.
    always_comb begin
        state_d      = state_q;
        dout_d       = '0;
        dout_valid_d = 1'b0;
        data_cnt_d   = data_cnt_q;
        post_cnt_d   = post_cnt_q;
        emit         = 1'b0;

        case (state_q)
            IDLE: begin
                if (r1_hit) begin
                    state_d      = HEADER;
                    dout_d       = {8'hAA, CH_ID, CURRENT_TIME, THRESHOLD_VAL, BASELINE, {HDR_PAD{1'b0}}};
                    dout_valid_d = 1'b1;
                    data_cnt_d   = '0;
                    post_cnt_d   = POST_LEN;
                end
            end
            HEADER: begin
                state_d = DATA;
                emit    = 1'b1;
            end
            DATA: begin
                if ((post_cnt_q == '0) || (data_cnt_q == MAX_LEN)) begin
                    state_d      = FOOTER;
                    dout_d       = {8'h55, CH_ID, data_cnt_q, hit_field, {FTR_PAD{1'b0}}};
                    dout_valid_d = 1'b1;
                end else begin
                    emit = 1'b1;
                end
            end
            FOOTER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Invalid slots leave a gap on DOUT and freeze both counters.
        if (emit && r2_valid) begin
            dout_d       = r2_data;
            dout_valid_d = 1'b1;
            data_cnt_d   = data_cnt_q + 1'b1;
            post_cnt_d   = r2_hit ? POST_LEN : (post_cnt_q - 1'b1);
        end
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            state_q    <= IDLE;
            DOUT       <= '0;
            DOUT_VALID <= 1'b0;
            data_cnt_q <= '0;
            post_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            DOUT       <= dout_d;
            DOUT_VALID <= dout_valid_d;
            data_cnt_q <= data_cnt_d;
            post_cnt_q <= post_cnt_d;
        end
    end

    assign TRIGGERED = (state_q == HEADER) || (state_q == DATA);

endmodule

// File: tb/tb_trg_frame_builder.sv
// Bench for trg_frame_builder: scheduled random/directed stimulus, frame-level reference model.
module tb_trg_frame_builder;

    localparam int N       = 1200;
    localparam int POST    = 38;
    localparam int ACQ     = 100;
    localparam int NOISE   = -10000;
    localparam int HIGH    = -10001;
    localparam int RANDHIT = -10002;
    localparam logic [48:0] TIME_BASE = 49'h1_2345_6789_ABCD;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] tdata = '0;
    logic         tvalid = 1'b0;
    logic signed [12:0] thr = 13'sd8;
    logic signed [11:0] bl = -12'sd2037;
    logic [48:0]  ctime = '0;
    logic [127:0] dout;
    logic         dout_valid;
    logic         triggered;

    always #5 clk = ~clk;

    trg_frame_builder dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESET   (rst),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TVALID (tvalid),
        .THRESHOLD_VAL (thr),
        .BASELINE      (bl),
        .CURRENT_TIME  (ctime),
        .DOUT          (dout),
        .DOUT_VALID    (dout_valid),
        .TRIGGERED     (triggered)
    );

    // Stimulus schedule, one entry per clock edge, and the expected outputs after that edge.
    logic [127:0]       s_data [N];
    bit                 s_valid[N];
    bit                 s_rst  [N];
    logic signed [12:0] s_thr  [N];
    logic signed [11:0] s_bl   [N];
    logic [127:0]       e_dout [N];
    bit                 e_valid[N];
    bit                 e_trg  [N];

    int p;
    logic signed [12:0] cur_thr = 13'sd8;
    logic signed [11:0] cur_bl  = -12'sd2037;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [127:0] hdr_w [16];
    int           hdr_e [16];
    logic [127:0] foot_w[16];
    int           foot_e[16];
    int           n_hdr = 0;
    int           n_foot = 0;
    bit           trg_prev = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_beat(input int lvl);
        logic [127:0] b;
        int s;
        int k;
        b = '0;
        for (int j = 0; j < 8; j++) begin
            case (lvl)
                NOISE, RANDHIT: s = ($urandom_range(0, 1) == 0) ? -2038 : -2036;
                HIGH:           s = int'($urandom_range(9, 2047));
                default:        s = lvl;
            endcase
            b[16*j+4 +: 12] = 12'(s);
            b[16*j +: 4]    = 4'($urandom);
        end
        if (lvl == RANDHIT) begin
            k = int'($urandom_range(0, 7));
            b[16*k+4 +: 12] = 12'($urandom_range(9, 2047));
        end
        return b;
    endfunction

    task automatic put(input int lvl, input bit vld, input bit rs);
        if (p < N) begin
            s_data[p]  = mk_beat(lvl);
            s_valid[p] = vld;
            s_rst[p]   = rs;
            s_thr[p]   = cur_thr;
            s_bl[p]    = cur_bl;
            p++;
        end
    endtask

    // A beat captured at edge m is judged against the threshold present at edge m+1.
    function automatic bit beat_hit(input int m);
        logic signed [11:0] s;
        int thr_i;
        if (!s_valid[m] || s_rst[m]) return 1'b0;
        thr_i = int'(s_thr[(m + 1 < N) ? m + 1 : m]);
        for (int j = 0; j < 8; j++) begin
            s = s_data[m][16*j+4 +: 12];
            if (int'(s) > thr_i) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [48:0] ts_at(input int k);
        return TIME_BASE + 49'(k);
    endfunction

    // Frame-level model: find the trigger beat, place header at +1, data at +2 onwards,
    // stop on post-trigger exhaustion or the length cap, abandon on reset.
    task automatic build_expected();
        int t, k, m, e, cnt, post, hc;
        bit done;
        logic [15:0] hfield;
        for (int i = 0; i < N; i++) begin
            e_dout[i] = '0; e_valid[i] = 1'b0; e_trg[i] = 1'b0;
        end
        t = 0;
        while (t < N) begin
            k = t;
            while (k < N && !beat_hit(k)) k++;
            if (k + 1 >= N) break;
            if (s_rst[k+1]) begin
                t = k + 2;
                continue;
            end
            e_valid[k+1] = 1'b1;
            e_trg[k+1]   = 1'b1;
            e_dout[k+1]  = {8'hAA, 8'h00, ts_at(k + 1), s_thr[k+1], s_bl[k+1], 38'b0};
            cnt = 0; post = POST; hc = 0; m = k; done = 1'b0;
            while (!done) begin
                e = m + 2;
                if (e >= N) begin
                    t = N; done = 1'b1;
                end else if (s_rst[e]) begin
                    t = e + 1; done = 1'b1;
                end else if (m > k && (cnt == ACQ || post == 0)) begin
`ifdef FOOTER_HITCNT_EN
                    hfield = 16'(hc);
`else
                    hfield = 16'h0;
`endif
                    e_valid[e] = 1'b1;
                    e_dout[e]  = {8'h55, 8'h00, 16'(cnt), hfield, 80'b0};
                    t = e + 1; done = 1'b1;
                end else begin
                    e_trg[e] = 1'b1;
                    if (s_valid[m]) begin
                        e_valid[e] = 1'b1;
                        e_dout[e]  = s_data[m];
                        cnt++;
                        if (beat_hit(m)) begin
                            post = POST;
                            if (hc < 65535) hc++;
                        end else begin
                            post--;
                        end
                    end
                    m++;
                end
            end
        end
    endtask

    initial begin
        int p1, p3, p4, p5;
        logic [15:0] exp_hits;

        for (int i = 0; i < 16; i++) begin
            hdr_w[i] = '0; foot_w[i] = '0; hdr_e[i] = 0; foot_e[i] = 0;
        end

        // Reset for 10 edges with noise, then idle noise.
        p = 0;
        for (int i = 0; i < 10; i++) put(NOISE, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) put(NOISE, 1'b1, 1'b0);
        // 10 beats at 1239, 20 at -1628, then noise.
        p1 = p;
        for (int i = 0; i < 10; i++) put(1239, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) put(-1628, 1'b1, 1'b0);
        for (int i = 0; i < 60; i++) put(NOISE, 1'b1, 1'b0);
        // 150 continuous over-threshold beats.
        for (int i = 0; i < 150; i++) put(HIGH, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) put(NOISE, 1'b1, 1'b0);
        // Two short signal sets 100 beats apart.
        p3 = p;
        for (int i = 0; i < 4; i++)   put(HIGH, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) put(NOISE, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)   put(HIGH, 1'b1, 1'b0);
        for (int i = 0; i < 60; i++)  put(NOISE, 1'b1, 1'b0);
        // TVALID gap mid-frame; baseline changes after trigger.
        p4 = p;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) cur_bl = 12'sd100;
            put(HIGH, 1'b1, 1'b0);
        end
        for (int i = 0; i < 10; i++) put(NOISE, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)  put(HIGH, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) put(NOISE, 1'b1, 1'b0);
        // Reset during DATA, then a fresh frame.
        p5 = p;
        for (int i = 0; i < 10; i++) put(HIGH, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) put(NOISE, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++)  put(NOISE, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) put(NOISE, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)  put(HIGH, 1'b1, 1'b0);
        for (int i = 0; i < 60; i++) put(NOISE, 1'b1, 1'b0);
        // Random sparse hits with random valid drops.
        for (int i = 0; i < 400; i++)
            put(($urandom_range(0, 19) == 0) ? RANDHIT : NOISE, $urandom_range(0, 9) != 0, 1'b0);
        while (p < N) put(NOISE, 1'b1, 1'b0);

        build_expected();

        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            rst    = s_rst[k];
            tdata  = s_data[k];
            tvalid = s_valid[k];
            thr    = s_thr[k];
            bl     = s_bl[k];
            ctime  = ts_at(k);
            @(posedge clk);
            #1;
            check($sformatf("dout_valid@%0d", k), 128'(dout_valid), 128'(e_valid[k]));
            check($sformatf("triggered@%0d", k),  128'(triggered),  128'(e_trg[k]));
            check($sformatf("dout@%0d", k),       dout,             e_dout[k]);
            if (triggered && !trg_prev && n_hdr < 16) begin
                hdr_w[n_hdr] = dout; hdr_e[n_hdr] = k; n_hdr++;
            end
            if (dout_valid && !triggered && n_foot < 16) begin
                foot_w[n_foot] = dout; foot_e[n_foot] = k; n_foot++;
            end
            trg_prev = triggered;
        end

`ifdef FOOTER_HITCNT_EN
        exp_hits = 16'd10;
`else
        exp_hits = 16'd0;
`endif
        // Spot checks of individual frames, derived directly from the stimulus plan.
        check("p1_hdr_tag",   128'(hdr_w[0][127:112]), 128'(16'hAA00));
        check("p1_hdr_ts",    128'(hdr_w[0][111:63]),  128'(ts_at(p1 + 1)));
        check("p1_hdr_thr",   128'(hdr_w[0][62:50]),   128'(13'd8));
        check("p1_hdr_bl",    128'(hdr_w[0][49:38]),   128'(12'h80B));
        check("p1_ftr_tag",   128'(foot_w[0][127:112]), 128'(16'h5500));
        check("p1_ftr_cnt",   128'(foot_w[0][111:96]), 128'(16'd48));
        check("p1_ftr_hits",  128'(foot_w[0][95:80]),  128'(exp_hits));
        check("p2_ftr_cap",   128'(foot_w[1][111:96]), 128'(16'd100));
        check("p2_rearm",     128'((hdr_e[2] - foot_e[1]) <= 2), 128'(1));
        check("p3_ts_a",      128'(hdr_w[3][111:63]),  128'(ts_at(p3 + 1)));
        check("p3_ts_b",      128'(hdr_w[4][111:63]),  128'(ts_at(p3 + 105)));
        check("p4_hdr_bl",    128'(hdr_w[5][49:38]),   128'(12'h80B));
        check("p4_ftr_cnt",   128'(foot_w[5][111:96]), 128'(16'd48));
        check("p5_abort_ts",  128'(hdr_w[6][111:63]),  128'(ts_at(p5 + 1)));
        check("p5_fresh_bl",  128'(hdr_w[7][49:38]),   128'(12'd100));
        check("p5_ftr_cnt",   128'(foot_w[6][111:96]), 128'(16'd42));
        check("p5_ftr_after", 128'(foot_e[6] > hdr_e[7]), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
